band_envelope: RTL

- Downstream of the five bandpass FIR stages. Consumes their signed 18-bit band outputs once per audio sample.
- Time-multiplexes a single magnitude/envelope datapath across all bands, one band per clock.
- Produces one unsigned 8-bit level per band, intended for the spectrum display and threshold logic.

---
 rtl/band_envelope.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/band_envelope.sv
// Time-multiplexed per-band magnitude envelope follower, one band per clock.
// Optional BAND_PEAK_HOLD_EN adds per-band peak-hold outputs on peaks.
module band_envelope #(
  parameter int NBANDS      = 5,
  parameter int IN_W        = 18,
  parameter int OUT_W       = 8,
  parameter int DECAY_SHIFT = 4
`ifdef BAND_PEAK_HOLD_EN
  , parameter int HOLD_FRAMES = 32
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  logic [NBANDS*IN_W-1:0]  y_flat,
  output logic [NBANDS*OUT_W-1:0] levels,
  output logic                    levels_valid,
  output logic                    overrun
`ifdef BAND_PEAK_HOLD_EN
  , output logic [NBANDS*OUT_W-1:0] peaks
`endif
);

  localparam int SH = IN_W - 1 - OUT_W;
  localparam int XW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PUBLISH
  } state_t;

  state_t                   state_q, state_d;
  logic [XW-1:0]            idx_q, idx_d;
  logic [NBANDS*IN_W-1:0]   cap_q, cap_d;
  logic [OUT_W-1:0]         env_q [NBANDS];
  logic [OUT_W-1:0]         env_d [NBANDS];
  logic [NBANDS*OUT_W-1:0]  levels_q, levels_d;
  logic                     overrun_q, overrun_d;

  logic [IN_W-1:0]  y;
  logic [IN_W-1:0]  nabs;
  logic [IN_W-2:0]  mag;
  logic [OUT_W-1:0] s;
  logic [OUT_W-1:0] env_cur;
  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] fall;
  logic [OUT_W-1:0] env_new;
  logic             last;
  logic             unused_bits;

`ifdef BAND_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  logic [OUT_W-1:0]        peak_q [NBANDS];
  logic [OUT_W-1:0]        peak_d [NBANDS];
  logic [HW-1:0]           hold_q [NBANDS];
  logic [HW-1:0]           hold_d [NBANDS];
  logic [NBANDS*OUT_W-1:0] peaks_q, peaks_d;
`endif

  // Shared datapath: magnitude, scale and envelope step for band idx
  always_comb begin
    y       = cap_q[idx_q*IN_W +: IN_W];
    nabs    = ~y + 1'b1;
    mag     = y[IN_W-2:0];
    if (y[IN_W-1]) begin
      if (y == {1'b1, {(IN_W-1){1'b0}}}) mag = '1;
      else mag = nabs[IN_W-2:0];
    end
    s       = mag[IN_W-2 -: OUT_W];
    env_cur = env_q[idx_q];
    dec     = env_cur >> DECAY_SHIFT;
    if (dec == '0) dec = OUT_W'(1);
    fall    = env_cur - dec;
    if (s >= env_cur) env_new = s;
    else if (fall > s) env_new = fall;
    else env_new = s;
    last        = (idx_q == XW'(NBANDS - 1));
    unused_bits = ^mag[SH-1:0] ^ nabs[IN_W-1];
  end

  // Frame sequencing, envelope writeback and publish
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_d     = cap_q;
    env_d     = env_q;
    levels_d  = levels_q;
    overrun_d = overrun_q | (ready && (state_q != IDLE));
`ifdef BAND_PEAK_HOLD_EN
    peak_d  = peak_q;
    hold_d  = hold_q;
    peaks_d = peaks_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ready) begin
          cap_d   = y_flat;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        env_d[idx_q] = env_new;
`ifdef BAND_PEAK_HOLD_EN
        if (env_new >= peak_q[idx_q]) begin
          peak_d[idx_q] = env_new;
          hold_d[idx_q] = HW'(HOLD_FRAMES);
        end else if (hold_q[idx_q] != '0) begin
          hold_d[idx_q] = hold_q[idx_q] - 1'b1;
        end else begin
          peak_d[idx_q] = peak_q[idx_q] - 1'b1;
        end
`endif
        if (last) begin
          state_d = PUBLISH;
          for (int b = 0; b < NBANDS; b++) begin
            levels_d[b*OUT_W +: OUT_W] = env_d[b];
`ifdef BAND_PEAK_HOLD_EN
            peaks_d[b*OUT_W +: OUT_W] = peak_d[b];
`endif
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cap_q     <= '0;
      levels_q  <= '0;
      overrun_q <= 1'b0;
      for (int b = 0; b < NBANDS; b++) env_q[b] <= '0;
`ifdef BAND_PEAK_HOLD_EN
      peaks_q <= '0;
      for (int b = 0; b < NBANDS; b++) begin
        peak_q[b] <= '0;
        hold_q[b] <= '0;
      end
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_q     <= cap_d;
      levels_q  <= levels_d;
      overrun_q <= overrun_d;
      env_q     <= env_d;
`ifdef BAND_PEAK_HOLD_EN
      peaks_q <= peaks_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
`endif
    end
  end

  assign levels       = levels_q;
  assign levels_valid = (state_q == PUBLISH);
  assign overrun      = overrun_q;
`ifdef BAND_PEAK_HOLD_EN
  assign peaks        = peaks_q;
`endif

endmodule
